// File: rtl/alu_shift_sched.sv
// rtl/alu_shift_sched.sv - round-robin shared iterative shifter with valid/ready response port
module alu_shift_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int STEP       = 4,
    localparam int SHAMT_W   = $clog2(DATA_WIDTH)
) (
    input  logic                       clk,
    input  logic                       arst_i,
    input  logic [1:0]                 req_valid_i,
    output logic [1:0]                 req_ready_o,
    input  logic [1:0][DATA_WIDTH-1:0] req_data_i,
    input  logic [1:0][SHAMT_W-1:0]    req_shamt_i,
    input  logic [1:0]                 req_left_i,
    input  logic [1:0]                 req_arith_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [DATA_WIDTH-1:0]      rsp_data_o,
    output logic                       rsp_id_o,
    output logic                       busy_o
);

    // STEP may equal DATA_WIDTH, so it is held one bit wider than a shift amount
    localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W+1)'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  acc;
    logic [SHAMT_W-1:0]     rem;
    logic                   dir_left;
    logic                   arith;
    logic                   id;
    logic                   last_grant;

    logic                   any_req;
    logic                   grant_id;
    logic [SHAMT_W-1:0]     step_k;
    logic [DATA_WIDTH-1:0]  acc_step;
    logic [SHAMT_W-1:0]     rem_step;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        any_req     = |req_valid_i;
        grant_id    = (req_valid_i == 2'b11) ? ~last_grant : req_valid_i[1];
        req_ready_o = 2'b00;
        if (state == IDLE && !arst_i && any_req) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    // One shift step of at most STEP bits on the accumulator
    always_comb begin
        step_k = ({1'b0, rem} < STEP_C) ? rem : STEP_C[SHAMT_W-1:0];
        if (dir_left) begin
            acc_step = acc << step_k;
        end else if (arith) begin
            acc_step = $unsigned($signed(acc) >>> step_k);
        end else begin
            acc_step = acc >> step_k;
        end
        rem_step = rem - step_k;
    end

    // Sequencer: accept in IDLE, iterate in SHIFT, hold the result in DONE until taken
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            state       <= IDLE;
            acc         <= '0;
            rem         <= '0;
            dir_left    <= 1'b0;
            arith       <= 1'b0;
            id          <= 1'b0;
            last_grant  <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_id_o    <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        acc        <= req_data_i[grant_id];
                        rem        <= req_shamt_i[grant_id];
                        dir_left   <= req_left_i[grant_id];
                        arith      <= req_arith_i[grant_id];
                        id         <= grant_id;
                        last_grant <= grant_id;
                        busy_o     <= 1'b1;
                        if (req_shamt_i[grant_id] == '0) begin
                            state       <= DONE;
                            rsp_valid_o <= 1'b1;
                            rsp_data_o  <= req_data_i[grant_id];
                            rsp_id_o    <= grant_id;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_step;
                    rem <= rem_step;
                    if (rem_step == '0) begin
                        state       <= DONE;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= acc_step;
                        rsp_id_o    <= id;
                    end
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
